// File: rtl/ff_bist_pkg.sv
// Shared definitions for the flip-flop BIST checker: FSM state encoding,
// Galois LFSR tap masks per width and the vector index reported for the
// INIT (reset) vector.
package ff_bist_pkg;

    // Checker sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Vector index recorded for the reset vector applied in INIT.
    localparam logic [15:0] INIT_IDX = 16'hFFFF;

    // Number of DRAIN cycles needed to flush the stimulus/compare pipeline.
    localparam int DRAIN_CYCLES = 2;

    // Maximal-length tap masks for a right-shifting Galois LFSR.
    // Unlisted widths fall back to the 16-bit mask (truncated by the caller).
    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] taps;
        case (width)
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0E08;
            13:      taps = 32'h0000_1C80;
            14:      taps = 32'h0000_3802;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_B400;
            24:      taps = 32'h00E1_0000;
            32:      taps = 32'hA300_0000;
            default: taps = 32'h0000_B400;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/ff_bist_checker_lfsr_gen.sv
// Galois LFSR (right shift) used as the stimulus source of the flop BIST.
// load has priority over step; reset and load both return to SEED.
// Only the two low bits are needed by the checker (d and active-low reset),
// so only those leave the block.
module lfsr_gen #(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(16'hACE1),
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(16'hB400)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    output logic [1:0] state_lo
);

    logic [LFSR_W-1:0] state;

    // Shift register: reload to SEED on reset/load, otherwise advance on step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED;
        end else if (load) begin
            state <= SEED;
        end else if (step) begin
            state <= (state >> 1) ^ (state[0] ? TAPS : '0);
        end
    end

    assign state_lo = state[1:0];

endmodule

// File: rtl/ff_bist_checker.sv
// Flip-flop BIST checker. Drives registered pseudo-random d / active-low
// reset stimulus into a DUT flop and a golden flop, compares their q/qbar
// two cycles after each issued vector and reports a saturating mismatch
// count plus a pass flag when the run completes.
// Optional feature: define FF_BIST_FIRST_ERR_EN to capture the vector index
// of the first mismatch on first_err_idx (otherwise it is tied to zero).
module ff_bist_checker
    import ff_bist_pkg::*;
#(
    parameter int                NUM_VECTORS = 100,
    parameter int                LFSR_W      = 16,
    parameter logic [LFSR_W-1:0] SEED        = LFSR_W'(16'hACE1),
    parameter int                ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 dut_q,
    input  logic                 dut_qbar,
    input  logic                 gold_q,
    input  logic                 gold_qbar,
    output logic                 stim_d,
    output logic                 stim_rstn,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [15:0]          first_err_idx
);

    localparam logic [LFSR_W-1:0] TAPS     = LFSR_W'(lfsr_taps(LFSR_W));
    localparam logic [15:0]       LAST_VEC = 16'(NUM_VECTORS - 1);

    state_t      state;
    logic [15:0] vec_cnt;
    logic        drain_cnt;
    logic [1:0]  lfsr_lo;
    logic        start_ok;
    logic        issue;
    logic        cmp_v1;
    logic        cmp_v2;
    logic        mismatch;
    logic        hit;

    // A start pulse only counts when the checker is not already running.
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));

    // INIT issues the reset vector, each RUN cycle issues one random vector.
    assign issue = (state == ST_INIT) || (state == ST_RUN);

    // Either output differing from the golden flop is a failure.
    assign mismatch = (dut_q != gold_q) || (dut_qbar != gold_qbar);
    assign hit      = cmp_v2 && mismatch;

    lfsr_gen #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED),
        .TAPS   (TAPS)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ST_INIT),
        .step     (state == ST_RUN),
        .state_lo (lfsr_lo)
    );

    // Sequencer with registered stimulus and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            vec_cnt   <= '0;
            drain_cnt <= 1'b0;
            stim_d    <= 1'b0;
            stim_rstn <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            // NOTE: later non-blocking assignments in this block override these
            // defaults, so the flops sit in reset in every state except RUN.
            stim_d    <= 1'b0;
            stim_rstn <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_INIT;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end
                end
                ST_INIT: begin
                    state   <= ST_RUN;
                    vec_cnt <= '0;
                end
                ST_RUN: begin
                    stim_d    <= lfsr_lo[0];
                    stim_rstn <= lfsr_lo[1];
                    if (vec_cnt == LAST_VEC) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 1'b0;
                    end else begin
                        vec_cnt <= vec_cnt + 16'd1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == 1'(DRAIN_CYCLES - 1)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // The last vector is compared on this very edge.
                        pass  <= (err_count == '0) && !hit;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Compare-valid pipeline: stage 1 travels with the registered stimulus,
    // stage 2 lines up with the cycle in which the flops show its effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_v1 <= 1'b0;
            cmp_v2 <= 1'b0;
        end else begin
            cmp_v1 <= issue;
            cmp_v2 <= cmp_v1;
        end
    end

    // Saturating mismatch counter, cleared when a new run is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (start_ok) begin
            err_count <= '0;
        end else if (hit && !(&err_count)) begin
            err_count <= err_count + 1'b1;
        end
    end

`ifdef FF_BIST_FIRST_ERR_EN
    logic [15:0] idx1;
    logic [15:0] idx2;
    logic        first_seen;

    // Vector index carried alongside the compare-valid pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx1 <= '0;
            idx2 <= '0;
        end else begin
            idx1 <= (state == ST_INIT) ? INIT_IDX : vec_cnt;
            idx2 <= idx1;
        end
    end

    // Capture the index of the first mismatch of a run and then freeze.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_err_idx <= '0;
            first_seen    <= 1'b0;
        end else if (start_ok) begin
            first_err_idx <= '0;
            first_seen    <= 1'b0;
        end else if (hit && !first_seen) begin
            first_err_idx <= idx2;
            first_seen    <= 1'b1;
        end
    end
`else
    assign first_err_idx = '0;
`endif

endmodule
